// File: rtl/cu_pkg.sv
// Shared definitions for the ALU operand collector: default widths,
// FSM state encoding and the funct3 operation codes understood by the ALU.
package cu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RS1  = 3'd1;
    localparam logic [2:0] ST_RS2  = 3'd2;
    localparam logic [2:0] ST_EXE  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_operand_collector.sv
// Collects ALU operands from a sync-read register file, runs the external ALU
// and hands the result to writeback. Define ALU_FWD_EN to forward the last writeback.
module alu_operand_collector
    import cu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RAW-1:0]  in_rs1,
    input  logic [RAW-1:0]  in_rs2,
    input  logic [RAW-1:0]  in_rd,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7,
    output logic            rf_ren,
    output logic [RAW-1:0]  rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic [2:0]      alu_funct3,
    output logic            alu_funct7,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_y,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RAW-1:0]  wb_rd,
    output logic [XLEN-1:0] wb_data
);

    logic [2:0]      state_q, state_d;
    logic [RAW-1:0]  rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] imm_q;
    logic            use_imm_q;
    logic [2:0]      funct3_q;
    logic            funct7_q;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [RAW-1:0]  wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            accept;
    logic            rs1_zero, rs2_zero;
    logic            hit1, hit2;
    logic [XLEN-1:0] fwd_data;
    logic            b_from_rf;

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign rs1_zero = (rs1_q == '0);
    assign rs2_zero = (rs2_q == '0);

`ifdef ALU_FWD_EN
    logic            fwd_valid_q;
    logic [RAW-1:0]  fwd_rd_q;
    logic [XLEN-1:0] fwd_data_q;

    // Only one instruction is in flight, so the store cannot change between
    // the source-read states and EXE of the instruction that consults it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
        end else if (wb_valid && wb_ready) begin
            fwd_valid_q <= 1'b1;
            fwd_rd_q    <= wb_rd_q;
            fwd_data_q  <= wb_data_q;
        end
    end

    assign hit1     = fwd_valid_q && !rs1_zero && (rs1_q == fwd_rd_q);
    assign hit2     = fwd_valid_q && !rs2_zero && (rs2_q == fwd_rd_q);
    assign fwd_data = fwd_data_q;
`else
    assign hit1     = 1'b0;
    assign hit2     = 1'b0;
    assign fwd_data = '0;
`endif

    // The RS2 read only returns during EXE; RF data is itself a register
    // output, so operand B passes it through there and freezes it on exit.
    assign b_from_rf = (state_q == ST_EXE) && !use_imm_q && !rs2_zero && !hit2;

    assign in_ready   = (state_q == ST_IDLE);
    assign wb_valid   = (state_q == ST_WB);
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = b_from_rf ? rf_rdata : alu_b_q;
    assign alu_funct3 = funct3_q;
    assign alu_funct7 = funct7_q;

    always_comb begin
        rf_ren   = 1'b0;
        rf_raddr = '0;
        case (state_q)
            ST_RS1: begin
                if (!rs1_zero && !hit1) begin
                    rf_ren   = 1'b1;
                    rf_raddr = rs1_q;
                end
            end
            ST_RS2: begin
                if (!use_imm_q && !rs2_zero && !hit2) begin
                    rf_ren   = 1'b1;
                    rf_raddr = rs2_q;
                end
            end
            default: begin
                rf_ren   = 1'b0;
                rf_raddr = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RS1;
                end
            end
            ST_RS1: begin
                state_d = ST_RS2;
            end
            ST_RS2: begin
                state_d = ST_EXE;
                if (rs1_zero) begin
                    alu_a_d = '0;
                end else if (hit1) begin
                    alu_a_d = fwd_data;
                end else begin
                    alu_a_d = rf_rdata;
                end
                if (use_imm_q) begin
                    alu_b_d = imm_q;
                end else if (hit2) begin
                    alu_b_d = fwd_data;
                end else begin
                    alu_b_d = '0;
                end
            end
            ST_EXE: begin
                alu_b_d   = alu_b;
                wb_data_d = alu_y;
                wb_rd_d   = rd_q;
                state_d   = (rd_q != '0) ? ST_WB : ST_IDLE;
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            funct3_q  <= 3'b000;
            funct7_q  <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            if (accept) begin
                rs1_q     <= in_rs1;
                rs2_q     <= in_rs2;
                rd_q      <= in_rd;
                imm_q     <= in_imm;
                use_imm_q <= in_use_imm;
                funct3_q  <= in_funct3;
                funct7_q  <= in_funct7;
            end
        end
    end

endmodule

// File: doc/alu_operand_collector.md
ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RAW, default 5, register address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-004 in_valid  in  1  decoded instruction valid.
REQ-005 in_ready  out  1  collector can accept an instruction.
REQ-006 in_rs1, in_rs2, in_rd  in  RAW each  source and destination register indices.
REQ-007 in_imm  in  XLEN  immediate; in_use_imm in 1 selects imm as operand B.
REQ-008 in_funct3  in  3, in_funct7  in  1  ALU operation select.
REQ-009 rf_ren  out  1, rf_raddr  out  RAW, rf_rdata  in  XLEN  register-file sync read port; data valid the cycle after rf_ren.
REQ-010 alu_funct3  out  3, alu_funct7  out  1, alu_a  out  XLEN, alu_b  out  XLEN  registered operands to the combinational ALU.
REQ-011 alu_y  in  XLEN  ALU result.
REQ-012 wb_valid  out  1, wb_ready  in  1, wb_rd  out  RAW, wb_data  out  XLEN  writeback handshake.

Function
REQ-013 FSM states IDLE, RS1, RS2, EXE, WB.
REQ-014 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready latches rs1/rs2/rd/imm/use_imm/funct3/funct7 and enters RS1.
REQ-015 RS1: rf_ren=1, rf_raddr=rs1; next RS2.
REQ-016 RS2: capture rf_rdata into alu_a; if !use_imm, rf_ren=1, rf_raddr=rs2; next EXE.
REQ-017 EXE: capture alu_b = use_imm ? imm : rf_rdata at entry; alu_funct3/alu_funct7 driven from latched fields; at end of EXE latch alu_y into wb_data and rd into wb_rd.
REQ-018 From EXE: rd!=0 -> WB; rd==0 -> IDLE, no wb_valid.
REQ-019 WB: wb_valid=1, wb_rd/wb_data stable until wb_ready; wb_valid&&wb_ready -> IDLE.
REQ-020 Latency: accept edge T; wb_valid first high in cycle T+4; throughput one instruction per >=5 cycles.
REQ-021 Source index 0 SHALL read as zero: rf_ren held 0 for that read, operand forced to 0.
REQ-022 rf_ren SHALL be 0 in IDLE, EXE, WB and in RS2 when use_imm=1.
REQ-023 in_valid while not IDLE SHALL be ignored (no latch, no side effect).
REQ-024 Datapath SHALL be pure XLEN bits; no sign or width conversion of imm (decoder supplies extended value).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=1 (after release), rf_ren=0, rf_raddr=0, alu_a=alu_b=0, alu_funct3=0, alu_funct7=0, wb_valid=0, wb_rd=0, wb_data=0.
REQ-026 Reset mid-operation SHALL drop the in-flight instruction; no wb_valid afterwards for it.

Configuration
REQ-027 Macro ALU_FWD_EN defined: collector keeps last written (rd,data) on each wb handshake; a nonzero rs1/rs2 equal to that rd SHALL take the stored data, with rf_ren suppressed for that read; latency unchanged.
REQ-028 ALU_FWD_EN undefined: no forwarding storage; all nonzero sources read from the register file.
REQ-029 Forwarding store SHALL be invalidated by reset.

Structure
REQ-030 Shared package cu_pkg SHALL hold XLEN/RAW defaults, FSM state encoding, funct3 operation constants.
REQ-031 Single module; no sub-module, operand-select logic inline.

Verification
REQ-032 Reset mid-EXE -> all outputs at REQ-025 values, no wb_valid for 10 cycles with in_valid=0.
REQ-033 rs1=3 (RF=5), rs2=4 (RF=7), funct3=000, funct7=1, rd=2 -> alu_a=5, alu_b=7, wb_data=0xFFFFFFFE, wb_rd=2 at T+4.
REQ-034 rs1=1 (RF=0x10), use_imm=1, imm=0x1, funct3=001 -> single rf read, wb_data=0x20.
REQ-035 rs1=0, rs2=0, funct3=000, rd=0 -> rf_ren never 1, no wb_valid, in_ready back at T+4.
REQ-036 wb_ready held 0 for 6 cycles -> wb_valid/wb_rd/wb_data stable, in_ready=0, in_valid pulses ignored.
REQ-037 ALU_FWD_EN: write x5=0x55 via wb, next inst rs1=5 -> rf_ren not asserted for rs1, alu_a=0x55.
